uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one UART_TX (range 2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 4096, SHALL set the idle clocks after which a packet lock is released (range 1..65535).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rstb  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  SHALL carry the per-requester byte-valid flags.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry the per-requester bytes; requester k uses bits [8k+7:8k].
REQ-007 req_last  input  NUM_REQ  SHALL mark the final byte of a requester's packet.
REQ-008 req_ready  output  NUM_REQ  SHALL be the per-requester accept strobe; a byte transfers when valid and ready are both high.
REQ-009 tx_dv  output  1  SHALL be the start pulse to UART_TX i_TX_DV.
REQ-010 tx_byte  output  8  SHALL be the byte to UART_TX i_TX_Byte.
REQ-011 tx_active  input  1  SHALL be UART_TX o_TX_Active.
REQ-012 tx_done  input  1  SHALL be UART_TX o_TX_Done, a one-cycle pulse at stop-bit end.
REQ-013 grant_id  output  clog2(NUM_REQ)  SHALL give the index of the last granted requester.
REQ-014 locked  output  1  SHALL be high while a multi-byte packet holds the grant.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, SEND and WAIT_DONE.
REQ-017 IDLE, lock clear, tx_active low, any req_valid high: SHALL pick the winner round-robin, first valid index at or after rr_ptr with wrap NUM_REQ-1 -> 0.
REQ-018 IDLE, lock set, tx_active low: SHALL consider only the locked requester; all others SHALL be ignored even if valid.
REQ-019 On grant in IDLE, req_ready[winner] SHALL be high combinationally that same cycle (one-hot, one cycle only).
REQ-020 On grant, the byte SHALL be captured into tx_byte, grant_id updated, and the FSM SHALL move to SEND.
REQ-021 SEND SHALL drive tx_dv high for exactly one cycle, then move to WAIT_DONE.
REQ-022 WAIT_DONE SHALL hold until tx_done=1, then return to IDLE.
REQ-023 tx_byte SHALL stay stable from capture until the next grant.
REQ-024 Minimum spacing between tx_dv pulses SHALL be one IDLE cycle after tx_done.
REQ-025 Captured byte with req_last=0: locked SHALL be set; rr_ptr SHALL be unchanged.
REQ-026 Captured byte with req_last=1: locked SHALL be cleared and rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-027 A 16-bit idle counter SHALL count IDLE cycles while locked and the locked requester is not valid.
REQ-028 The idle counter SHALL clear on every grant.
REQ-029 When the idle counter reaches LOCK_TIMEOUT, lock SHALL clear and rr_ptr SHALL advance past the locked requester in that cycle.
REQ-030 If the timeout cycle coincides with the locked requester going valid, the grant SHALL win and the lock SHALL be kept.
REQ-031 IDLE with tx_active high (external or stale transmission): no grant SHALL be issued.
REQ-032 req_ready SHALL be zero in SEND and WAIT_DONE.
REQ-033 A tx_done seen outside WAIT_DONE SHALL be ignored.

Reset
REQ-034 rstb low SHALL immediately force state=IDLE, tx_dv=0, tx_byte=0, req_ready=0, grant_id=0, locked=0, busy=0, rr_ptr=0, idle counter=0.
REQ-035 Reset mid-transmission SHALL abandon the byte with no replay; after release the first grant SHALL start from requester 0.

Verification
REQ-036 Req0 valid, data 0x41, last=1 -> req_ready[0] for 1 cycle, tx_dv next cycle, tx_byte=0x41, busy until tx_done, rr_ptr=1.
REQ-037 All 4 valid with last=1, held -> grant order 0,1,2,3,0; each tx_dv follows the prior tx_done by at least 2 cycles.
REQ-038 Req2 sends 0x10,0x11 (last=0) then 0x12 (last=1) while req1 stays valid -> bytes 10,11,12 sent back-to-back before any req1 byte; locked high across them.
REQ-039 Req3 sends one byte with last=0 then drops valid, LOCK_TIMEOUT=8 -> locked falls 8 IDLE cycles later; the next grant goes to req0.
REQ-040 rstb pulsed low during WAIT_DONE -> all outputs 0 asynchronously; a later tx_done pulse produces no tx_dv.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte sources. Sources are
//   granted round-robin; a packet (bytes up to and including req_last) keeps
//   the grant until its last byte or until the owner has been silent for
//   LOCK_TIMEOUT idle clocks.
// Ports
//   clk, rstb              clock, asynchronous active-low reset
//   req_valid/data/last    per-requester byte offer (byte k at [8k+7:8k])
//   req_ready              one-hot accept strobe, combinational in IDLE
//   tx_dv, tx_byte         start pulse and byte towards UART_TX
//   tx_active, tx_done     UART_TX status (busy level, end-of-byte pulse)
//   grant_id               index of the most recently granted requester
//   locked                 a multi-byte packet currently owns the grant
//   busy                   arbiter is not in IDLE
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_dv,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] scan_pick;
  logic          scan_hit;
  logic [IW-1:0] winner;
  logic          grant;
  logic [15:0]   idle_cnt;
  logic          lock_idle;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    scan_hit  = 1'b0;
    scan_pick = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!scan_hit && req_valid[IW'(idx)]) begin
        scan_hit  = 1'b1;
        scan_pick = IW'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = scan_pick;
    unique case (state)
      IDLE: begin
        if (!tx_active) begin
          // While locked, grant_id still names the packet owner.
          if (locked) begin
            winner = grant_id;
            grant  = req_valid[grant_id];
          end else begin
            grant = scan_hit;
          end
          if (grant) state_next = SEND;
        end
      end
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Gated by rstb so the strobe drops the instant reset asserts.
  always_comb begin
    req_ready = '0;
    if (grant && rstb) req_ready[winner] = 1'b1;
  end

  assign tx_dv     = (state == SEND);
  assign busy      = (state != IDLE);
  assign lock_idle = (state == IDLE) && locked && !req_valid[grant_id];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_byte  <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
    end else if (grant) begin
      // A grant always wins over a coincident timeout.
      tx_byte  <= req_data[{winner, 3'b000} +: 8];
      grant_id <= winner;
      idle_cnt <= '0;
      if (req_last[winner]) begin
        locked <= 1'b0;
        rr_ptr <= next_idx(winner);
      end else begin
        locked <= 1'b1;
      end
    end else if (lock_idle) begin
      if (idle_cnt == 16'(LOCK_TIMEOUT - 1)) begin
        locked   <= 1'b0;
        idle_cnt <= '0;
        rr_ptr   <= next_idx(grant_id);
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int LT = 8;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        locked;
  logic        busy;

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done),
    .grant_id(grant_id), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_count = 0;
  int lk_idle = 0;
  int xfer_len = 4;
  int gid_log[$];
  logic [7:0] byte_log[$];
  logic [8:0] srcq [4][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Requester sources: each drains its own queue, popping on a handshake.
  initial begin
    logic [3:0] hs;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) void'(srcq[k].pop_front());
        if (srcq[k].size() > 0) begin
          req_valid[k] = 1'b1;
          req_data[8*k +: 8] = srcq[k][0][7:0];
          req_last[k] = srcq[k][0][8];
        end else begin
          req_valid[k] = 1'b0;
          req_data[8*k +: 8] = 8'h00;
          req_last[k] = 1'b0;
        end
      end
    end
  end

  // UART_TX stand-in: active after tx_dv, tx_done pulse after xfer_len clocks.
  initial begin
    int n;
    tx_active = 1'b0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        n = xfer_len;
        @(posedge clk); #1 tx_active = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_done = 1'b1; tx_active = 1'b0;
        @(posedge clk); #1 tx_done = 1'b0;
      end
    end
  end

  // Reference model and per-cycle comparison.
  initial begin
    int m_phase, m_ptr, m_gid, m_idle;
    bit m_lock;
    logic [7:0] m_byte;
    int w, bestd, d, last_done;
    bit done_seen;
    logic [3:0] e_ready;
    m_phase = 0; m_ptr = 0; m_gid = 0; m_idle = 0; m_lock = 0; m_byte = '0;
    last_done = 0; done_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstb) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_dv", tx_dv, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        m_phase = 0; m_ptr = 0; m_gid = 0; m_idle = 0; m_lock = 0; m_byte = '0;
        lk_idle = 0;
      end else begin
        w = -1;
        if (m_phase == 0 && !tx_active) begin
          if (m_lock) begin
            if (req_valid[m_gid]) w = m_gid;
          end else begin
            bestd = 4;
            for (int k = 0; k < 4; k++) begin
              d = (k - m_ptr + 4) % 4;
              if (req_valid[k] && d < bestd) begin bestd = d; w = k; end
            end
          end
        end
        e_ready = '0;
        if (w >= 0) e_ready[w] = 1'b1;
        chk("req_ready", req_ready, e_ready);
        chk("tx_dv", tx_dv, m_phase == 1);
        chk("tx_byte", tx_byte, m_byte);
        chk("grant_id", grant_id, m_gid);
        chk("locked", locked, m_lock);
        chk("busy", busy, m_phase != 0);

        if (tx_dv) begin
          gid_log.push_back(int'(grant_id));
          byte_log.push_back(tx_byte);
          dv_count++;
          if (done_seen) chk("dv_gap_ge2", (cyc - last_done) >= 2, 1);
          done_seen = 0;
        end
        if (tx_done) begin last_done = cyc; done_seen = 1; end
        if (busy) lk_idle = 0;
        else if (locked) lk_idle++;

        if (w >= 0) begin
          m_byte = req_data[8*w +: 8];
          m_gid = w; m_idle = 0; m_phase = 1;
          if (req_last[w]) begin m_lock = 0; m_ptr = (w + 1) % 4; end
          else m_lock = 1;
        end else if (m_phase == 0 && m_lock && !req_valid[m_gid]) begin
          m_idle++;
          if (m_idle == LT) begin m_lock = 0; m_idle = 0; m_ptr = (m_gid + 1) % 4; end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (m_phase == 2 && tx_done) begin
          m_phase = 0;
        end
      end
    end
  end

  task automatic wait_log(input int n);
    int t = 0;
    while (!(gid_log.size() >= n && busy == 1'b0) && t < 400) begin
      @(negedge clk); #1; t++;
    end
    chk("wait_log_timeout", t < 400, 1);
  endtask

  task automatic chk_log(input string nm, input int base, input int ids[], input int bytes[]);
    for (int i = 0; i < ids.size(); i++) begin
      if (base + i < gid_log.size()) begin
        chk({nm, "_id"}, gid_log[base+i], ids[i]);
        chk({nm, "_byte"}, byte_log[base+i], bytes[i]);
      end else begin
        chk({nm, "_missing"}, base + i, gid_log.size());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, t;
    rstb = 1'b0;
    #3;
    chk("init_busy", busy, 0);
    chk("init_dv", tx_dv, 0);
    chk("init_ready", req_ready, 0);
    chk("init_locked", locked, 0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;

    // Single byte from requester 0.
    @(posedge clk);
    srcq[0].push_back({1'b1, 8'h41});
    wait_log(1);
    chk_log("t1", 0, '{0}, '{8'h41});

    // Restart from pointer 0, then all four valid and held.
    @(posedge clk); #1 rstb = 1'b0;
    @(posedge clk); #1 rstb = 1'b1;
    @(posedge clk);
    base = gid_log.size();
    srcq[0].push_back({1'b1, 8'hA0});
    srcq[0].push_back({1'b1, 8'hA4});
    srcq[1].push_back({1'b1, 8'hA1});
    srcq[2].push_back({1'b1, 8'hA2});
    srcq[3].push_back({1'b1, 8'hA3});
    wait_log(base + 5);
    chk_log("t2", base, '{0, 1, 2, 3, 0}, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4});

    // Locked packet from requester 2 while requester 1 waits.
    @(posedge clk);
    base = gid_log.size();
    srcq[2].push_back({1'b0, 8'h10});
    srcq[2].push_back({1'b0, 8'h11});
    srcq[2].push_back({1'b1, 8'h12});
    @(posedge clk);
    srcq[1].push_back({1'b1, 8'h55});
    wait_log(base + 4);
    chk_log("t3", base, '{2, 2, 2, 1}, '{8'h10, 8'h11, 8'h12, 8'h55});

    // Lock timeout: requester 3 goes silent mid-packet.
    @(posedge clk);
    base = gid_log.size();
    srcq[3].push_back({1'b0, 8'h33});
    wait_log(base + 1);
    t = 0;
    while (locked && t < 40) begin @(negedge clk); #1; t++; end
    chk("t4_lock_released", locked, 0);
    chk("t4_idle_clocks", lk_idle, LT);
    @(posedge clk);
    srcq[1].push_back({1'b1, 8'h61});
    srcq[0].push_back({1'b1, 8'h60});
    wait_log(base + 3);
    chk_log("t4", base, '{3, 0, 1}, '{8'h33, 8'h60, 8'h61});

    // Reset during WAIT_DONE; the late tx_done must not restart anything.
    xfer_len = 12;
    @(posedge clk);
    d0 = dv_count;
    srcq[1].push_back({1'b1, 8'h77});
    t = 0;
    while (dv_count == d0 && t < 20) begin @(negedge clk); #1; t++; end
    chk("t5_dv_seen", dv_count, d0 + 1);
    repeat (3) @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_dv", tx_dv, 0);
    chk("t5_byte", tx_byte, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_locked", locked, 0);
    chk("t5_ready", req_ready, 0);
    @(posedge clk); #1 rstb = 1'b1;
    d0 = dv_count;
    repeat (16) @(posedge clk);
    chk("t5_no_replay", dv_count, d0);
    xfer_len = 4;

    // First grant after reset starts from requester 0.
    @(posedge clk);
    base = gid_log.size();
    srcq[2].push_back({1'b1, 8'h22});
    srcq[0].push_back({1'b1, 8'h20});
    wait_log(base + 2);
    chk_log("t6", base, '{0, 2}, '{8'h20, 8'h22});

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
